sn76489: RTL and testbench

Cycle-driven model of the TI SN76489 programmable sound generator: three square-wave tone channels, one noise channel, per-channel 4-bit attenuation and a signed mixed audio output. It sits on the CPU write bus of the sound subsystem. The bench drives it through the `intf_sn76489` interface. The per-channel outputs `tone1_s`, `tone2_s`, `tone3_s` and `noise_s` are internal signals with those exact names, because the bench probes them hierarchically.

---
 rtl/sn76489.sv | 199 +++++++++++++++++++
 tb/tb_sn76489.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sn76489.sv
// SN76489 sound generator: three square-wave tone channels, one LFSR noise channel,
// 4-bit attenuation per channel and a registered signed mix, written via latch/data bytes.
module sn76489 #(
  parameter bit clock_div_16_g = 1'b1
) (
  input  logic              clock_i,
  input  logic              res_n_i,
  input  logic              clock_en_i,
  input  logic              ce_n_i,
  input  logic              we_n_i,
  input  logic [7:0]        d_i,
  output logic              ready_o,
  output logic signed [7:0] aout_o
);

  localparam logic [3:0] PreLast = clock_div_16_g ? 4'd15 : 4'd1;

  function automatic logic [4:0] att_amp(input logic [3:0] att);
    case (att)
      4'd0:    att_amp = 5'd31;
      4'd1:    att_amp = 5'd25;
      4'd2:    att_amp = 5'd20;
      4'd3:    att_amp = 5'd16;
      4'd4:    att_amp = 5'd12;
      4'd5:    att_amp = 5'd10;
      4'd6:    att_amp = 5'd8;
      4'd7:    att_amp = 5'd6;
      4'd8:    att_amp = 5'd5;
      4'd9:    att_amp = 5'd4;
      4'd10:   att_amp = 5'd3;
      4'd11:   att_amp = 5'd2;
      4'd12:   att_amp = 5'd2;
      4'd13:   att_amp = 5'd2;
      4'd14:   att_amp = 5'd1;
      default: att_amp = 5'd0;
    endcase
  endfunction

  logic [3:0]       pre_q, pre_d;
  logic             tick;
  logic             strobe, strobe_q, wr;
  logic             ready_q, ready_d;
  logic [4:0]       busy_q, busy_d;
  logic [2:0]       addr_q, addr_d, tgt;
  logic [2:0][9:0]  period_q, period_d;
  logic [3:0][3:0]  att_q, att_d;
  logic [2:0]       nctrl_q, nctrl_d;
  logic             lfsr_reload;
  logic [2:0][9:0]  cnt_q, cnt_d;
  logic [2:0]       tout_q, tout_d, held;
  logic [5:0]       ncnt_q, ncnt_d, nlim;
  logic             nsrc_q, nsrc_d, shift;
  logic [14:0]      lfsr_q, lfsr_d;
  logic [3:0]       bits;
  logic [3:0][7:0]  chan_d;
  logic [7:0]       aout_d;
  logic signed [7:0] tone1_s, tone2_s, tone3_s, noise_s, aout_q;

  assign tick   = clock_en_i && (pre_q == PreLast);
  assign strobe = ~ce_n_i & ~we_n_i;
  // Only a fresh strobe edge while idle starts a write.
  assign wr     = strobe & ~strobe_q & ready_q;

  always_comb begin
    pre_d   = pre_q;
    ready_d = ready_q;
    busy_d  = busy_q;
    if (clock_en_i) pre_d = tick ? 4'd0 : pre_q + 4'd1;
    if (wr) begin
      ready_d = 1'b0;
      busy_d  = 5'd0;
    end else if (!ready_q && clock_en_i) begin
      if (busy_q == 5'd31) ready_d = 1'b1;
      else                 busy_d  = busy_q + 5'd1;
    end
  end

  always_comb begin
    addr_d      = addr_q;
    period_d    = period_q;
    att_d       = att_q;
    nctrl_d     = nctrl_q;
    lfsr_reload = 1'b0;
    tgt         = d_i[7] ? d_i[6:4] : addr_q;
    if (wr) begin
      if (d_i[7]) addr_d = d_i[6:4];
      case (tgt)
        3'b000: if (d_i[7]) period_d[0][3:0] = d_i[3:0]; else period_d[0][9:4] = d_i[5:0];
        3'b010: if (d_i[7]) period_d[1][3:0] = d_i[3:0]; else period_d[1][9:4] = d_i[5:0];
        3'b100: if (d_i[7]) period_d[2][3:0] = d_i[3:0]; else period_d[2][9:4] = d_i[5:0];
        3'b110: begin
          if (d_i[7]) begin
            nctrl_d     = d_i[2:0];
            lfsr_reload = 1'b1;
          end
        end
        default: att_d[tgt[2:1]] = d_i[3:0];
      endcase
    end
  end

  always_comb begin
    cnt_d  = cnt_q;
    tout_d = tout_q;
    held   = '0;
    for (int i = 0; i < 3; i++) begin
      held[i] = (period_q[i] <= 10'd1);
      if (tick) begin
        if (cnt_q[i] == 10'd0) begin
          cnt_d[i]  = held[i] ? 10'd0 : period_q[i] - 10'd1;
          tout_d[i] = held[i] | ~tout_q[i];
        end else begin
          cnt_d[i]  = cnt_q[i] - 10'd1;
          tout_d[i] = held[i] | tout_q[i];
        end
      end
    end
  end

  always_comb begin
    ncnt_d = ncnt_q;
    nsrc_d = nsrc_q;
    shift  = 1'b0;
    case (nctrl_q[1:0])
      2'b00:   nlim = 6'd15;
      2'b01:   nlim = 6'd31;
      default: nlim = 6'd63;
    endcase
    if (nctrl_q[1:0] == 2'b11) begin
      shift = tout_d[2] & ~tout_q[2];
    end else if (tick) begin
      if (ncnt_q >= nlim) begin
        ncnt_d = 6'd0;
        nsrc_d = ~nsrc_q;
        shift  = ~nsrc_q;
      end else begin
        ncnt_d = ncnt_q + 6'd1;
      end
    end
    lfsr_d = lfsr_q;
    if (lfsr_reload) lfsr_d = 15'h4000;
    else if (shift)  lfsr_d = {nctrl_q[2] ? lfsr_q[0] ^ lfsr_q[1] : lfsr_q[0], lfsr_q[14:1]};
  end

  always_comb begin
    bits   = {lfsr_q[0], tout_q};
    chan_d = '0;
    for (int i = 0; i < 4; i++) begin
      chan_d[i] = bits[i] ? {3'b000, att_amp(att_q[i])} : 8'd0 - {3'b000, att_amp(att_q[i])};
    end
    aout_d = chan_d[0] + chan_d[1] + chan_d[2] + chan_d[3];
  end

  always_ff @(posedge clock_i or negedge res_n_i) begin
    if (!res_n_i) begin
      pre_q    <= '0;
      strobe_q <= 1'b0;
      ready_q  <= 1'b1;
      busy_q   <= '0;
      addr_q   <= '0;
      period_q <= '0;
      att_q    <= '1;
      nctrl_q  <= '0;
      cnt_q    <= '0;
      tout_q   <= '0;
      ncnt_q   <= '0;
      nsrc_q   <= 1'b0;
      lfsr_q   <= 15'h4000;
      tone1_s  <= '0;
      tone2_s  <= '0;
      tone3_s  <= '0;
      noise_s  <= '0;
      aout_q   <= '0;
    end else begin
      pre_q    <= pre_d;
      strobe_q <= strobe;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      addr_q   <= addr_d;
      period_q <= period_d;
      att_q    <= att_d;
      nctrl_q  <= nctrl_d;
      cnt_q    <= cnt_d;
      tout_q   <= tout_d;
      ncnt_q   <= ncnt_d;
      nsrc_q   <= nsrc_d;
      lfsr_q   <= lfsr_d;
      tone1_s  <= chan_d[0];
      tone2_s  <= chan_d[1];
      tone3_s  <= chan_d[2];
      noise_s  <= chan_d[3];
      aout_q   <= aout_d;
    end
  end

  assign ready_o = ready_q;
  assign aout_o  = aout_q;

endmodule

// File: tb/tb_sn76489.sv
// Bench for sn76489: randomized register programming checked against timing and
// amplitude rules computed directly from the chip's behaviour.
module tb_sn76489;

  logic              clk      = 1'b0;
  logic              res_n    = 1'b1;
  logic              clock_en = 1'b1;
  logic              ce_n     = 1'b1;
  logic              we_n     = 1'b1;
  logic [7:0]        d        = 8'h00;
  logic              ready;
  logic signed [7:0] aout;

  int tests_run    = 0;
  int tests_failed = 0;
  int amp_tab [16] = '{31, 25, 20, 16, 12, 10, 8, 6, 5, 4, 3, 2, 2, 2, 1, 0};

  sn76489 #(.clock_div_16_g(1'b1)) dut (
    .clock_i    (clk),
    .res_n_i    (res_n),
    .clock_en_i (clock_en),
    .ce_n_i     (ce_n),
    .we_n_i     (we_n),
    .d_i        (d),
    .ready_o    (ready),
    .aout_o     (aout)
  );

  always #5 clk = ~clk;

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  function automatic int chan_val(input int ch);
    case (ch)
      0:       return int'(dut.tone1_s);
      1:       return int'(dut.tone2_s);
      2:       return int'(dut.tone3_s);
      default: return int'(dut.noise_s);
    endcase
  endfunction

  function automatic int abs_i(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int chan_sum();
    return chan_val(0) + chan_val(1) + chan_val(2) + chan_val(3);
  endfunction

  // White-noise LFSR: shift right, bit0 ^ bit1 enters at bit 14.
  function automatic int white_step(input int s);
    int fb;
    fb = (s ^ (s >> 1)) & 1;
    return (s >> 1) | (fb << 14);
  endfunction

  task automatic write_byte(input logic [7:0] b);
    int n;
    n = 0;
    while (ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (ready !== 1'b1) begin
      tests_run++;
      tests_failed++;
      $display("FAIL write_wait_ready: ready=%b required 1", ready);
    end
    ce_n = 1'b0;
    we_n = 1'b0;
    d    = b;
    @(negedge clk);
    ce_n = 1'b1;
    we_n = 1'b1;
  endtask

  task automatic wait_change(input int ch, input int bound, output int cycles, output bit ok);
    int prev;
    prev   = chan_val(ch);
    cycles = 0;
    ok     = 1'b0;
    while (cycles < bound) begin
      @(negedge clk);
      cycles++;
      if (chan_val(ch) != prev) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_pos(input int ch, input int bound, output bit ok);
    int n;
    n  = 0;
    ok = 1'b0;
    while (n < bound) begin
      if (chan_val(ch) > 0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    res_n = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if (aout !== 8'sd0) begin
      tests_failed++;
      $display("FAIL reset_aout: got %0d required 0", aout);
    end
    tests_run++;
    if (ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_ready: got %b required 1", ready);
    end
    for (int c = 0; c < 4; c++) begin
      tests_run++;
      if (chan_val(c) != 0) begin
        tests_failed++;
        $display("FAIL reset_chan%0d: got %0d required 0", c, chan_val(c));
      end
    end
    res_n = 1'b1;
    repeat (50) @(negedge clk);
    tests_run++;
    if (aout !== 8'sd0 || chan_sum() != 0 || abs_i(chan_val(0)) + abs_i(chan_val(3)) != 0) begin
      tests_failed++;
      $display("FAIL post_reset_silent: aout=%0d sum=%0d required 0", aout, chan_sum());
    end
  endtask

  task automatic test_tone1();
    int cyc;
    bit ok1, ok2, ok;
    write_byte(8'h80);
    write_byte(8'h04);
    write_byte(8'h90);
    wait_change(0, 3000, cyc, ok1);
    wait_change(0, 1100, cyc, ok2);
    tests_run++;
    if (!(ok1 && ok2)) begin
      tests_failed++;
      $display("FAIL tone1_sync: toggles seen=%0d%0d required 11", ok1, ok2);
    end
    for (int k = 0; k < 3; k++) begin
      wait_change(0, 1100, cyc, ok);
      tests_run++;
      if (!ok || cyc != 1024) begin
        tests_failed++;
        $display("FAIL tone1_half_period: got %0d clocks required 1024", cyc);
      end
      tests_run++;
      if (abs_i(chan_val(0)) != 31) begin
        tests_failed++;
        $display("FAIL tone1_amp: got %0d required +/-31", chan_val(0));
      end
      tests_run++;
      if (int'(aout) != chan_val(0)) begin
        tests_failed++;
        $display("FAIL tone1_aout: got %0d required %0d", aout, chan_val(0));
      end
    end
  endtask

  task automatic test_tone_random();
    int p, a, cyc;
    bit ok;
    logic [9:0] pv;
    for (int it = 0; it < 2; it++) begin
      p  = $urandom_range(2, 40);
      a  = $urandom_range(0, 12);
      pv = p[9:0];
      write_byte({4'hA, pv[3:0]});
      write_byte({2'b00, pv[9:4]});
      write_byte(8'hB0 | 8'(a));
      wait_change(1, 2000, cyc, ok);
      wait_change(1, 2000, cyc, ok);
      for (int k = 0; k < 2; k++) begin
        wait_change(1, 2000, cyc, ok);
        tests_run++;
        if (!ok || cyc != p * 16) begin
          tests_failed++;
          $display("FAIL tone2_half_period p=%0d: got %0d clocks required %0d", p, cyc, p * 16);
        end
        tests_run++;
        if (abs_i(chan_val(1)) != amp_tab[a] || int'(aout) != chan_sum()) begin
          tests_failed++;
          $display("FAIL tone2_amp att=%0d: got %0d aout=%0d required +/-%0d sum %0d",
                   a, chan_val(1), aout, amp_tab[a], chan_sum());
        end
      end
    end
  endtask

  task automatic test_ready();
    int cnt;
    write_byte(8'hBF);
    write_byte(8'hA5);
    cnt = 0;
    while (ready === 1'b0 && cnt < 100) begin
      cnt++;
      if (cnt == 4) begin
        ce_n = 1'b0;
        we_n = 1'b0;
        d    = 8'hB0;
      end
      if (cnt == 6) begin
        ce_n = 1'b1;
        we_n = 1'b1;
      end
      @(negedge clk);
    end
    tests_run++;
    if (cnt != 32) begin
      tests_failed++;
      $display("FAIL ready_low_window: got %0d clocks required 32", cnt);
    end
    repeat (100) @(negedge clk);
    tests_run++;
    if (chan_val(1) != 0) begin
      tests_failed++;
      $display("FAIL ready_ignored_strobe: tone2=%0d required 0", chan_val(1));
    end
    write_byte(8'h00);
  endtask

  task automatic test_att_sweep();
    int cyc, a;
    bit ok;
    write_byte(8'h9F);
    write_byte(8'hB0);
    wait_change(1, 500, cyc, ok);
    wait_change(1, 500, cyc, ok);
    wait_change(1, 500, cyc, ok);
    tests_run++;
    if (!ok || cyc != 80) begin
      tests_failed++;
      $display("FAIL tone2_period5: got %0d clocks required 80", cyc);
    end
    for (int i = 0; i < 20; i++) begin
      if (i < 16) begin
        a = i;
        write_byte(8'hB0 | 8'(a));
      end else begin
        a = $urandom_range(0, 15);
        write_byte(8'(a));
      end
      repeat (3) @(negedge clk);
      tests_run++;
      if (abs_i(chan_val(1)) != amp_tab[a] || int'(aout) != chan_sum()) begin
        tests_failed++;
        $display("FAIL att_sweep att=%0d: got %0d aout=%0d required +/-%0d sum %0d",
                 a, chan_val(1), aout, amp_tab[a], chan_sum());
      end
    end
  endtask

  task automatic test_noise_white();
    int lfsr, exp;
    bit ok;
    write_byte(8'hE4);
    write_byte(8'hF0);
    wait_pos(3, 20000, ok);
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL noise_white_first_one: noise=%0d required 31", chan_val(3));
    end
    if (ok) begin
      lfsr = 32'h4000;
      repeat (14) lfsr = white_step(lfsr);
      repeat (256) @(negedge clk);
      for (int k = 0; k < 20; k++) begin
        exp = (lfsr & 1) ? 31 : -31;
        tests_run++;
        if (chan_val(3) != exp) begin
          tests_failed++;
          $display("FAIL noise_white_seq[%0d]: got %0d required %0d", k, chan_val(3), exp);
        end
        lfsr = white_step(lfsr);
        repeat (512) @(negedge clk);
      end
    end
  endtask

  task automatic test_noise_periodic();
    int exp;
    bit ok;
    write_byte(8'hE0);
    repeat (2) @(negedge clk);
    wait_pos(3, 9000, ok);
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL noise_periodic_first_one: noise=%0d required 31", chan_val(3));
    end
    if (ok) begin
      repeat (256) @(negedge clk);
      for (int k = 0; k < 16; k++) begin
        exp = (k % 15 == 0) ? 31 : -31;
        tests_run++;
        if (chan_val(3) != exp) begin
          tests_failed++;
          $display("FAIL noise_periodic[%0d]: got %0d required %0d", k, chan_val(3), exp);
        end
        repeat (512) @(negedge clk);
      end
    end
  endtask

  task automatic test_noise_tone3();
    int p, half, exp;
    bit ok;
    p    = $urandom_range(2, 9);
    half = p * 16;
    write_byte(8'hC0 | 8'(p));
    write_byte(8'h00);
    write_byte(8'hE3);
    repeat (2) @(negedge clk);
    wait_pos(3, 8000, ok);
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL noise_tone3_first_one p=%0d: noise=%0d required 31", p, chan_val(3));
    end
    if (ok) begin
      repeat (half) @(negedge clk);
      for (int k = 0; k < 16; k++) begin
        exp = (k % 15 == 0) ? 31 : -31;
        tests_run++;
        if (chan_val(3) != exp) begin
          tests_failed++;
          $display("FAIL noise_tone3[%0d] p=%0d: got %0d required %0d", k, p, chan_val(3), exp);
        end
        repeat (2 * half) @(negedge clk);
      end
    end
  endtask

  task automatic test_const_tone();
    int a, bad;
    a = $urandom_range(0, 14);
    write_byte(8'h81);
    write_byte(8'h00);
    write_byte(8'h90 | 8'(a));
    repeat (1100) @(negedge clk);
    bad = 0;
    repeat (200) begin
      @(negedge clk);
      if (chan_val(0) != amp_tab[a]) bad++;
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL const_tone att=%0d: tone1=%0d required %0d (%0d bad samples)",
               a, chan_val(0), amp_tab[a], bad);
    end
  endtask

  task automatic test_mid_reset();
    write_byte(8'h9F);
    res_n = 1'b0;
    #1;
    tests_run++;
    if (ready !== 1'b1 || aout !== 8'sd0) begin
      tests_failed++;
      $display("FAIL mid_reset_outputs: ready=%b aout=%0d required 1 and 0", ready, aout);
    end
    for (int c = 0; c < 4; c++) begin
      tests_run++;
      if (chan_val(c) != 0) begin
        tests_failed++;
        $display("FAIL mid_reset_chan%0d: got %0d required 0", c, chan_val(c));
      end
    end
    repeat (3) @(negedge clk);
    res_n = 1'b1;
    repeat (300) @(negedge clk);
    tests_run++;
    if (aout !== 8'sd0 || ready !== 1'b1 || abs_i(chan_val(0)) + abs_i(chan_val(1))
        + abs_i(chan_val(2)) + abs_i(chan_val(3)) != 0) begin
      tests_failed++;
      $display("FAIL mid_reset_silent: aout=%0d ready=%b required 0 and 1", aout, ready);
    end
  endtask

  initial begin
    test_reset();
    test_tone1();
    test_tone_random();
    test_ready();
    test_att_sweep();
    test_noise_white();
    test_noise_periodic();
    test_noise_tone3();
    test_const_tone();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
